// File: rtl/binary_window_3x3.sv
// binary_window_3x3
//   Turns a raster-ordered binary pixel stream into one 3x3 neighbourhood
//   per pixel (centred on that pixel, zero outside the frame). Two 1-bit
//   line buffers plus a two-column shift register supply the neighbours.
//   After the last pixel of a frame the block flushes the remaining
//   IMG_W+1 windows by itself while holding o_ready low.
//
// Ports
//   clk, rst        pixel clock, asynchronous active-high reset
//   i_valid/o_ready input handshake; transfer = i_valid & o_ready
//   i_sof           transfer is raster index 0 of a new frame
//   i_data          binary-stage word, pixel = (i_data != 0)
//   o_valid         single-cycle pulse, window outputs valid
//   o_window        bit 3*r+c = neighbour at (row r-1, col c-1), bit 4 = centre
//   o_x, o_y        centre coordinates
module binary_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic       i_sof,
    input  logic [9:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [8:0] o_window,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [9:0]  X_LAST = 10'(IMG_W - 1);
    localparam logic [9:0]  Y_LAST = 10'(IMG_H - 1);
    // Flush runs steps 0..IMG_W, then one idle cycle before re-opening input.
    localparam logic [10:0] F_IDLE = 11'(IMG_W + 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state_q;
    logic [9:0]       x_q, y_q;      // position of the next input index
    logic [10:0]      fcnt_q;
    logic [2:0]       c0_q, c1_q;    // older / newer shifted columns, bit r = row offset
    logic [IMG_W-1:0] lb0_q;         // previous line
    logic [IMG_W-1:0] lb1_q;         // line before that

    logic          accept, fstep, step, sof, emit, last;
    logic [9:0]    ex, ey, nx, ny, cx, cy;
    logic [AW-1:0] wa;
    logic [2:0]    nc;
    logic [8:0]    win, mask;

    always_comb begin
        o_ready = (state_q != S_FLUSH);
        accept  = i_valid & o_ready;
        fstep   = (state_q == S_FLUSH) && (fcnt_q != F_IDLE);
        step    = accept | fstep;
        sof     = accept & i_sof;

        // Index actually processed this cycle; SOF forces it to 0.
        ex = sof ? 10'd0 : x_q;
        ey = sof ? 10'd0 : y_q;
        wa = ex[AW-1:0];

        // New column: bottom = incoming pixel (0 while flushing), then lines above.
        nc = {accept & (i_data != 10'd0), lb0_q[wa], lb1_q[wa]};

        if (ex == X_LAST) begin
            nx = 10'd0;
            ny = ey + 10'd1;
        end else begin
            nx = ex + 10'd1;
            ny = ey;
        end

        // Centre trails the input by IMG_W+1; at column 0 it sits at the end
        // of the line two rows up and the new column is its (masked) right side.
        if (ex != 10'd0) begin
            cx = ex - 10'd1;
            cy = ey - 10'd1;
        end else begin
            cx = X_LAST;
            cy = ey - 10'd2;
        end

        last = accept && (ex == X_LAST) && (ey == Y_LAST);
        emit = fstep | (accept & ~i_sof & (state_q == S_RUN));

        win = {nc[2], c1_q[2], c0_q[2],
               nc[1], c1_q[1], c0_q[1],
               nc[0], c1_q[0], c0_q[0]};

        // Border masking also hides stale line-buffer rows and the previous
        // line's wrap-around column.
        mask = 9'h1FF;
        if (cx == 10'd0)   mask = mask & 9'b110_110_110;
        if (cx == X_LAST)  mask = mask & 9'b011_011_011;
        if (cy == 10'd0)   mask = mask & 9'b111_111_000;
        if (cy == Y_LAST)  mask = mask & 9'b000_111_111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            x_q      <= '0;
            y_q      <= '0;
            fcnt_q   <= '0;
            c0_q     <= '0;
            c1_q     <= '0;
            o_valid  <= 1'b0;
            o_window <= '0;
            o_x      <= '0;
            o_y      <= '0;
        end else begin
            o_valid <= emit;
            if (emit) begin
                o_window <= win & mask;
                o_x      <= cx;
                o_y      <= cy;
            end

            if (step) begin
                c0_q <= c1_q;
                c1_q <= nc;
            end

            if (accept) begin
                x_q <= nx;
                y_q <= ny;
                if (last) begin
                    state_q <= S_FLUSH;
                    fcnt_q  <= '0;
                end else if (ny >= 10'd2 || (ny == 10'd1 && nx != 10'd0)) begin
                    state_q <= S_RUN;
                end else begin
                    state_q <= S_FILL;
                end
            end else if (state_q == S_FLUSH) begin
                if (fstep) begin
                    fcnt_q <= fcnt_q + 11'd1;
                    x_q    <= nx;
                    y_q    <= ny;
                end else begin
                    state_q <= S_FILL;
                    x_q     <= '0;
                    y_q     <= '0;
                end
            end
        end
    end

    // Line buffers are deliberately not reset; masking covers stale rows.
    always_ff @(posedge clk) begin
        if (step) begin
            lb0_q[wa] <= nc[2];
            lb1_q[wa] <= nc[1];
        end
    end

endmodule
